sipo_deserializer: RTL and testbench

Serial-in/parallel-out stage that sits directly downstream of the team's D flip-flop. It consumes the registered single-bit stream (q) plus a qualifying strobe and assembles WIDTH-bit words. Completed words go out on a valid/ready interface through a one-deep holding register. The serial source cannot be stalled, so words that cannot be accepted are dropped and flagged with a sticky overflow.

---
 rtl/sipo_deserializer_pkg.sv | 12 +
 rtl/sipo_deserializer_if.sv | 25 ++
 rtl/sipo_bit_assembler.sv | 71 +++++++
 rtl/sipo_deserializer.sv | 90 +++++++++
 tb/tb_sipo_deserializer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserializer.
// Holds the holding-register state type used by the top level.
package sipo_pkg;

  localparam int unsigned SIPO_DEFAULT_WIDTH = 8;

  typedef enum logic {
    HOLD_EMPTY,
    HOLD_FULL
  } hold_state_t;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Word output handshake of the deserializer: word plus valid/ready.
// The producer (deserializer) uses master, the consumer uses slave.
interface sipo_deserializer_if
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic             word_rdy;

  modport master (
    output word_out,
    output word_vld,
    input  word_rdy
  );

  modport slave (
    input  word_out,
    input  word_vld,
    output word_rdy
  );

endinterface

// File: rtl/sipo_bit_assembler.sv
// Shift register and bit counter that assemble WIDTH-bit words from a
// qualified serial stream; pulses word_done with the completed word.
module sipo_bit_assembler
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             frame_start,
  output logic             word_done,
  output logic [WIDTH-1:0] word
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) begin
      return {cur[WIDTH-2:0], b};
    end else begin
      return {b, cur[WIDTH-1:1]};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign shifted = shift_in(shreg_q, bit_in);

  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    if (frame_start) begin
      // Realign: a bit arriving with frame_start is the first bit of the new word.
      if (bit_vld) begin
        shreg_d = shift_in('0, bit_in);
        cnt_d   = CntW'(1);
      end else begin
        shreg_d = '0;
        cnt_d   = '0;
      end
    end else if (bit_vld) begin
      shreg_d = shifted;
      if (cnt_q == CntLast) begin
        cnt_d     = '0;
        word_done = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign word = shifted;

endmodule

// File: rtl/sipo_deserializer.sv
// Deserializer top: bit assembler feeding a one-deep holding register with
// valid/ready output; words that find the register busy are dropped and flagged.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      bit_in,
  input  logic                      bit_vld,
  input  logic                      frame_start,
  sipo_deserializer_if.master       out_if,
  output logic                      overflow,
  input  logic                      ovf_clr
);

  if (WIDTH < 2) begin : g_width_chk
    $fatal(1, "sipo_deserializer: WIDTH must be >= 2");
  end

  hold_state_t      state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovf_q, ovf_d;
  logic             word_done;
  logic [WIDTH-1:0] asm_word;
  logic             word_vld;

  sipo_bit_assembler #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_assembler (
    .clk         (clk),
    .rstn        (rstn),
    .bit_in      (bit_in),
    .bit_vld     (bit_vld),
    .frame_start (frame_start),
    .word_done   (word_done),
    .word        (asm_word)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= HOLD_EMPTY;
      word_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d   = ovf_q & ~ovf_clr;
    unique case (state_q)
      HOLD_EMPTY: begin
        if (word_done) begin
          word_d  = asm_word;
          state_d = HOLD_FULL;
        end
      end
      HOLD_FULL: begin
        if (word_done) begin
          if (out_if.word_rdy) begin
            word_d = asm_word;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (out_if.word_rdy) begin
          state_d = HOLD_EMPTY;
        end
      end
      default: state_d = HOLD_EMPTY;
    endcase
  end

  always_comb begin
    word_vld = (state_q == HOLD_FULL);
  end

  assign out_if.word_vld = word_vld;
  assign out_if.word_out = word_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomized and directed bench for sipo_deserializer: an MSB-first and an
// LSB-first instance share stimulus; a queue-based model feeds a scoreboard.
module tb_sipo_deserializer;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, bit_in, bit_vld, frame_start, ovf_clr, rdy;
  logic ovf_m, ovf_l;

  sipo_deserializer_if #(.WIDTH(W)) m_if ();
  sipo_deserializer_if #(.WIDTH(W)) l_if ();

  assign m_if.word_rdy = rdy;
  assign l_if.word_rdy = rdy;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk         (clk),
    .rstn        (rstn),
    .bit_in      (bit_in),
    .bit_vld     (bit_vld),
    .frame_start (frame_start),
    .out_if      (m_if.master),
    .overflow    (ovf_m),
    .ovf_clr     (ovf_clr)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk         (clk),
    .rstn        (rstn),
    .bit_in      (bit_in),
    .bit_vld     (bit_vld),
    .frame_start (frame_start),
    .out_if      (l_if.master),
    .overflow    (ovf_l),
    .ovf_clr     (ovf_clr)
  );

  // Reference model state: received bits of the current word, holding status.
  bit           mbits[$];
  bit           m_held;
  bit           m_ovf;
  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];
  int           total = 0;
  int           bad   = 0;
  bit           mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_bits(input bit msb);
    logic [W-1:0] w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (msb) w[W-1-i] = mbits[i];
      else     w[i]     = mbits[i];
    end
    return w;
  endfunction

  task automatic model_update();
    bit           done;
    bit           drop;
    logic [W-1:0] wm, wl;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (!rstn) begin
      mbits.delete();
      m_held = 1'b0;
      m_ovf  = 1'b0;
      exp_m.delete();
      exp_l.delete();
      return;
    end
    if (frame_start) begin
      mbits.delete();
      if (bit_vld) mbits.push_back(bit_in);
    end else if (bit_vld) begin
      mbits.push_back(bit_in);
      if (mbits.size() == int'(W)) begin
        done = 1'b1;
        wm   = pack_bits(1'b1);
        wl   = pack_bits(1'b0);
        mbits.delete();
      end
    end
    drop = done && m_held && !rdy;
    if (done && !drop) begin
      exp_m.push_back(wm);
      exp_l.push_back(wl);
      m_held = 1'b1;
    end else if (m_held && rdy) begin
      m_held = 1'b0;
    end
    if (ovf_clr) m_ovf = 1'b0;
    if (drop)    m_ovf = 1'b1;
  endtask

  task automatic step(input logic b, input logic v, input logic fs, input logic r,
                      input logic c, input logic rs);
    bit_in      = b;
    bit_vld     = v;
    frame_start = fs;
    rdy         = r;
    ovf_clr     = c;
    rstn        = rs;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r, input logic r_last,
                           input bit gap);
    for (int i = int'(W) - 1; i >= 0; i--) begin
      step(w[i], 1'b1, 1'b0, (i == 0) ? r_last : r, 1'b0, 1'b1);
      if (gap && i != 0) step(1'b0, 1'b0, 1'b0, r, 1'b0, 1'b1);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, pops on each transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_vld", 32'(m_if.word_vld), 32'(m_held));
      chk("l_vld", 32'(l_if.word_vld), 32'(m_held));
      chk("m_ovf", 32'(ovf_m), 32'(m_ovf));
      chk("l_ovf", 32'(ovf_l), 32'(m_ovf));
      if (m_if.word_vld === 1'b1) begin
        if (exp_m.size() == 0) begin
          total++;
          bad++;
          $display("FAIL m_word: got %0h expected no word", m_if.word_out);
        end else begin
          chk("m_word", 32'(m_if.word_out), 32'(exp_m[0]));
          if (rdy) void'(exp_m.pop_front());
        end
      end
      if (l_if.word_vld === 1'b1) begin
        if (exp_l.size() == 0) begin
          total++;
          bad++;
          $display("FAIL l_word: got %0h expected no word", l_if.word_out);
        end else begin
          chk("l_word", 32'(l_if.word_out), 32'(exp_l[0]));
          if (rdy) void'(exp_l.pop_front());
        end
      end
    end
  end

  initial begin
    logic [6:0] seq;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    chk("rst_vld", 32'(m_if.word_vld), 32'd0);
    chk("rst_word", 32'(m_if.word_out), 32'd0);
    chk("rst_ovf", 32'(ovf_m), 32'd0);

    // Single word, consumer always ready.
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("t1_vld", 32'(m_if.word_vld), 32'd1);
    chk("t1_word", 32'(m_if.word_out), 32'hA5);
    chk("t1_ovf", 32'(ovf_m), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t1_vld_once", 32'(m_if.word_vld), 32'd0);

    // Back-pressure drops the second word.
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t2_word", 32'(m_if.word_out), 32'hA5);
    chk("t2_ovf", 32'(ovf_m), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2_vld", 32'(m_if.word_vld), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t2_ovf_clr", 32'(ovf_m), 32'd0);

    // Consume and complete in the same cycle.
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b1, 1'b0);
    chk("t3_word", 32'(m_if.word_out), 32'h22);
    chk("t3_vld", 32'(m_if.word_vld), 32'd1);
    chk("t3_ovf", 32'(ovf_m), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Gaps between bits, then realign with frame_start.
    send_word(8'hA5, 1'b1, 1'b1, 1'b1);
    chk("t4_gap_word", 32'(m_if.word_out), 32'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    seq = 7'b0011110;
    for (int i = 6; i >= 0; i--) step(seq[i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4_realign_m", 32'(m_if.word_out), 32'h1E);
    chk("t4_realign_l", 32'(l_if.word_out), 32'h78);

    // Reset while holding a word, overflowed, and mid-word.
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_vld", 32'(m_if.word_vld), 32'd0);
    chk("t5_word", 32'(m_if.word_out), 32'd0);
    chk("t5_ovf", 32'(ovf_m), 32'd0);
    send_word(8'h96, 1'b1, 1'b1, 1'b0);
    chk("t5_after", 32'(m_if.word_out), 32'h96);

    // Same stream, both bit orders.
    send_word(8'h69, 1'b1, 1'b1, 1'b0);
    chk("t6_msb", 32'(m_if.word_out), 32'h69);
    chk("t6_lsb", 32'(l_if.word_out), 32'h96);

    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(3) != 0), 1'($urandom_range(31) == 0),
           1'($urandom_range(1)), 1'($urandom_range(15) == 0), 1'($urandom_range(127) != 0));
    end

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("drain_m", 32'(exp_m.size()), 32'd0);
    chk("drain_l", 32'(exp_l.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
